// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the multicycle control FSM and its opcode
// class decoder.
//   state_e : control FSM states
//   cls_e   : instruction classes the control sequence distinguishes
//   OPC_*   : RV32 major opcodes (instruction bits [6:0])
// ---------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CL_LOAD  = 2'd0,
    CL_STORE = 2'd1,
    CL_ALU   = 2'd2,
    CL_NOP   = 2'd3
  } cls_e;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

endpackage

// File: rtl/multicycle_ctrl_op_class_decode.sv
// ---------------------------------------------------------------------------
// op_class_decode
// Combinational opcode -> instruction class map. Unrecognised opcodes map
// to CL_NOP and raise illegal.
//   opcode  in  7  instruction bits [6:0]
//   cls     out    instruction class
//   illegal out 1  opcode is not LOAD/STORE/OP/OP_IMM
// ---------------------------------------------------------------------------
module op_class_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_e       cls,
  output logic       illegal
);

  always_comb begin
    cls     = CL_NOP;
    illegal = 1'b1;
    case (opcode)
      OPC_LOAD: begin
        cls     = CL_LOAD;
        illegal = 1'b0;
      end
      OPC_STORE: begin
        cls     = CL_STORE;
        illegal = 1'b0;
      end
      OPC_OP, OPC_OPIMM: begin
        cls     = CL_ALU;
        illegal = 1'b0;
      end
      default: begin
        cls     = CL_NOP;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Multicycle control FSM sequencing a single-cycle datapath through
// FETCH / DECODE / EXEC / MEM / WB, walking a program from address 0.
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   start         in   one-cycle pulse, begins a run at address 0
//   instr_data    in   instruction word read combinationally at instruction_A
//   instruction_A out  program counter
//   RegWrite      out  register-file write strobe (one cycle, WB)
//   MemWrite      out  data-memory write strobe (one cycle, MEM of a store)
//   busy          out  high outside IDLE and HALT
//   done          out  high while in HALT
//   illegal_op    out  sticky unrecognised-opcode flag, cleared by start
//   retired       out  saturating count of retired instructions
//   state_dbg     out  current FSM state, for observation only
//
// Handshake: start is a single-cycle request that is accepted only while the
// controller is idle (IDLE or HALT, i.e. busy=0); it is silently dropped while
// busy=1. Acceptance is visible as busy rising on the next cycle, and the run
// completes when done rises, which holds until the next accepted start.
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instruction_A,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               busy,
  output logic               done,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   retired,
  output state_e             state_dbg
);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]     retired_q, retired_d;
  logic                 illegal_q, illegal_d;
  logic                 reg_write_q, reg_write_d;
  logic                 mem_write_q, mem_write_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 do_retire;

  cls_e cls;
  logic dec_illegal;

  // Class comes from the registered IR, which is stable from DECODE to retire.
  op_class_decode u_dec (
    .opcode  (ir_q[6:0]),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    do_retire = 1'b0;

    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d   = FETCH;
          pc_d      = '0;
          retired_d = '0;
          illegal_d = 1'b0;
        end
      end
      FETCH: begin
        ir_d    = instr_data;
        state_d = DECODE;
      end
      DECODE: begin
        // An all-zero word marks end of program and is not retired.
        state_d = (ir_q == '0) ? HALT : EXEC;
      end
      EXEC: begin
        case (cls)
          CL_LOAD, CL_STORE: state_d = MEM;
          CL_ALU:            state_d = WB;
          default: begin
            if (dec_illegal) illegal_d = 1'b1;
            do_retire = 1'b1;
          end
        endcase
      end
      MEM: begin
        if (cls == CL_STORE) do_retire = 1'b1;
        else                 state_d   = WB;
      end
      WB: begin
        do_retire = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (do_retire) begin
      retired_d = (retired_q == {CNT_W{1'b1}}) ? retired_q : retired_q + CNT_W'(1);
      // Last word of the program space ends the run; the PC does not wrap.
      if (pc_q == {ADDR_W{1'b1}}) begin
        state_d = HALT;
      end else begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = FETCH;
      end
    end

    // Outputs are registered from the next state so they line up with it.
    reg_write_d = (state_d == WB);
    mem_write_d = (state_d == MEM) && (cls == CL_STORE);
    busy_d      = (state_d != IDLE) && (state_d != HALT);
    done_d      = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      retired_q   <= '0;
      illegal_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      retired_q   <= retired_d;
      illegal_q   <= illegal_d;
      reg_write_q <= reg_write_d;
      mem_write_q <= mem_write_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign instruction_A = pc_q;
  assign RegWrite      = reg_write_q;
  assign MemWrite      = mem_write_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign illegal_op    = illegal_q;
  assign retired       = retired_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed table of programs plus randomized programs, each checked cycle by
// cycle against a latency-table model of the control sequence.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int ADDR_W  = 3;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 8;
  localparam int NW      = 8;
  localparam int VW      = 16;

  localparam logic [31:0] I_LW   = 32'h0000_2083;
  localparam logic [31:0] I_SW   = 32'h0011_2023;
  localparam logic [31:0] I_ADD  = 32'h0020_81B3;
  localparam logic [31:0] I_ADDI = 32'h0010_8093;
  localparam logic [31:0] I_ILL  = 32'h0000_007F;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instruction_A;
  logic               RegWrite, MemWrite, busy, done, illegal_op;
  logic [CNT_W-1:0]   retired;
  state_e             state_dbg;

  logic [31:0] prog [NW];

  always #5 clk = ~clk;

  assign instr_data = prog[instruction_A];

  multicycle_ctrl #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .instr_data    (instr_data),
    .instruction_A (instruction_A),
    .RegWrite      (RegWrite),
    .MemWrite      (MemWrite),
    .busy          (busy),
    .done          (done),
    .illegal_op    (illegal_op),
    .retired       (retired),
    .state_dbg     (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] halt_rec;
  int rw_q[$];
  int mw_q[$];

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Observed vector: {busy, done, RegWrite, MemWrite, illegal_op, pc, retired}
  function automatic logic [VW-1:0] obs();
    return {busy, done, RegWrite, MemWrite, illegal_op, instruction_A, retired};
  endfunction

  // Reference model: walks the program using the per-class latency table and
  // emits one expected output vector per cycle of the run.
  task automatic build_model();
    int         pc;
    int         lat;
    logic [7:0] ret;
    logic       ill, rw, mw, nop;
    logic [31:0] w;
    pc  = 0;
    ret = '0;
    ill = 1'b0;
    exp_q.delete();
    forever begin
      w = prog[pc];
      if (w == 32'h0) begin
        repeat (2) exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, ill, 3'(pc), ret});
        break;
      end
      rw = 1'b0; mw = 1'b0; nop = 1'b0;
      case (w[6:0])
        7'h03:        begin lat = 5; rw = 1'b1; end
        7'h23:        begin lat = 4; mw = 1'b1; end
        7'h33, 7'h13: begin lat = 4; rw = 1'b1; end
        default:      begin lat = 3; nop = 1'b1; end
      endcase
      for (int k = 1; k <= lat; k++)
        exp_q.push_back({1'b1, 1'b0, rw && (k == lat), mw && (k == lat), ill, 3'(pc), ret});
      if (ret != 8'hFF) ret = ret + 8'd1;
      if (nop) ill = 1'b1;
      if (pc == NW - 1) break;
      pc++;
    end
    halt_rec = {1'b0, 1'b1, 1'b0, 1'b0, ill, 3'(pc), ret};
  endtask

  // ---------------- driver ----------------
  // Pulses start, then compares every cycle (sampled at negedge) against the
  // model. poke re-asserts start during cycle 'poke' of the run.
  task automatic run_prog(input string tag, input int poke,
                          output int done_cyc, output int n_rw, output int n_mw);
    int c;
    logic [VW-1:0] e;
    build_model();
    rw_q.delete();
    mw_q.delete();
    done_cyc = -1; n_rw = 0; n_mw = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s cycle %0d", tag, c), obs(), e);
      if (RegWrite) begin n_rw++; rw_q.push_back(c); end
      if (MemWrite) begin n_mw++; mw_q.push_back(c); end
      if (done && done_cyc < 0) done_cyc = c;
      start = (c == poke);
      @(negedge clk); c++;
    end
    start = 1'b0;
    repeat (3) begin
      check($sformatf("%s halt cycle %0d", tag, c), obs(), halt_rec);
      if (RegWrite) n_rw++;
      if (MemWrite) n_mw++;
      if (done && done_cyc < 0) done_cyc = c;
      @(negedge clk); c++;
    end
  endtask

  task automatic load_words(input logic [NW*32-1:0] words);
    for (int i = 0; i < NW; i++) prog[i] = words[i*32 +: 32];
  endtask

  function automatic logic [NW*32-1:0] p8(input logic [31:0] a, b, c, d, e, f, g, h);
    return {h, g, f, e, d, c, b, a};
  endfunction

  // ---------------- directed table ----------------
  typedef struct packed {
    logic [NW*32-1:0]  words;
    int                poke;
    int                done_cyc;
    int                n_rw;
    int                n_mw;
    logic [CNT_W-1:0]  ret;
    logic              ill;
    logic [ADDR_W-1:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic [NW*32-1:0] words, input int poke, input int dc,
                              input int nrw, input int nmw, input logic [CNT_W-1:0] ret,
                              input logic ill, input logic [ADDR_W-1:0] pc);
    vec_t v;
    v.words = words; v.poke = poke; v.done_cyc = dc; v.n_rw = nrw; v.n_mw = nmw;
    v.ret = ret; v.ill = ill; v.pc = pc;
    return v;
  endfunction

  localparam int NV = 8;
  vec_t vecs [NV];

  initial begin
    int dc, nrw, nmw;
    vec_t v;

    for (int i = 0; i < NW; i++) prog[i] = 32'h0;

    // Load/store program; full 8-word ADDI; illegal then zero; ALU clearing
    // illegal; empty program; stores then load; all illegal; start while busy.
    vecs[0] = mk(p8(I_LW, I_SW, I_ADD, 0, 0, 0, 0, 0), 0, 16, 2, 1, 8'd3, 1'b0, 3'd3);
    vecs[1] = mk(p8(I_ADDI, I_ADDI, I_ADDI, I_ADDI, I_ADDI, I_ADDI, I_ADDI, I_ADDI),
                 0, 33, 8, 0, 8'd8, 1'b0, 3'd7);
    vecs[2] = mk(p8(I_ILL, 0, 0, 0, 0, 0, 0, 0), 0, 6, 0, 0, 8'd1, 1'b1, 3'd1);
    vecs[3] = mk(p8(I_ADD, 0, 0, 0, 0, 0, 0, 0), 0, 7, 1, 0, 8'd1, 1'b0, 3'd1);
    vecs[4] = mk(p8(0, 0, 0, 0, 0, 0, 0, 0), 0, 3, 0, 0, 8'd0, 1'b0, 3'd0);
    vecs[5] = mk(p8(I_SW, I_SW, I_LW, 0, 0, 0, 0, 0), 0, 16, 1, 2, 8'd3, 1'b0, 3'd3);
    vecs[6] = mk(p8(I_ILL, I_ILL, I_ILL, I_ILL, I_ILL, I_ILL, I_ILL, I_ILL),
                 0, 25, 0, 0, 8'd8, 1'b1, 3'd7);
    vecs[7] = mk(p8(I_ADD, I_ADD, I_ADD, 0, 0, 0, 0, 0), 7, 15, 3, 0, 8'd3, 1'b0, 3'd3);

    // ---- reset and IDLE ----
    rst = 1'b0;
    #50;
    check("in reset", obs(), '0);
    #50;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle cycle %0d", i), obs(), '0);
      check_int($sformatf("idle state %0d", i), int'(state_dbg), int'(IDLE));
    end

    // ---- table ----
    for (int t = 0; t < NV; t++) begin
      v = vecs[t];
      load_words(v.words);
      run_prog($sformatf("vec%0d", t), v.poke, dc, nrw, nmw);
      check_int($sformatf("vec%0d done cycle", t), dc, v.done_cyc);
      check_int($sformatf("vec%0d RegWrite pulses", t), nrw, v.n_rw);
      check_int($sformatf("vec%0d MemWrite pulses", t), nmw, v.n_mw);
      check($sformatf("vec%0d final", t), {3'b0, done, illegal_op, instruction_A, retired},
            {3'b0, 1'b1, v.ill, v.pc, v.ret});
      if (t == 0) begin
        check_int("ls RegWrite count", rw_q.size(), 2);
        check_int("ls MemWrite count", mw_q.size(), 1);
        if (rw_q.size() == 2 && mw_q.size() == 1) begin
          check_int("ls RegWrite cycle A", rw_q[0], 5);
          check_int("ls MemWrite cycle", mw_q[0], 9);
          check_int("ls RegWrite cycle B", rw_q[1], 13);
        end
      end
    end

    // ---- reset during MEM of a store ----
    load_words(p8(I_ADD, I_SW, 0, 0, 0, 0, 0, 0));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;            // cycle 1
    repeat (7) @(negedge clk);               // cycle 8: MEM of SW
    check_int("pre-reset MemWrite", int'(MemWrite), 1);
    check_int("pre-reset retired", int'(retired), 1);
    #2 rst = 1'b0;
    #1;
    check_int("async MemWrite drop", int'(MemWrite), 0);
    check_int("async state", int'(state_dbg), int'(IDLE));
    check("async outputs", obs(), '0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("post-reset cycle %0d", i), obs(), '0);
    end

    // ---- randomized programs ----
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NW; i++) begin
        case ($urandom_range(0, 9))
          0:       prog[i] = 32'h0;
          1, 2:    prog[i] = I_LW;
          3, 4:    prog[i] = I_SW;
          5:       prog[i] = I_ADD;
          6, 7:    prog[i] = I_ADDI;
          8:       prog[i] = I_ILL;
          default: prog[i] = $urandom;
        endcase
      end
      run_prog($sformatf("rand%0d", r), $urandom_range(0, 45), dc, nrw, nmw);
      check_int($sformatf("rand%0d done seen", r), int'(dc > 0), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
